// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage register with a two-entry skid buffer (main + skid).
// in_ready comes straight from a flop, so there is no combinational out_ready -> in_ready path.
module pipe_stage_skid #(
    parameter int DATA_W     = 128,
    parameter int CTRL_W     = 10,
    parameter int CLEAR_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        state;
    logic              ready_q;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              main_valid;
    logic              in_fire;
    logic              out_fire;

    assign main_valid = (state != EMPTY);
    assign in_fire    = in_valid & ready_q;
    assign out_fire   = main_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            ready_q   <= 1'b1;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            // Squash everything held and any same-cycle input beat.
            state     <= EMPTY;
            ready_q   <= 1'b1;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            if (CLEAR_DATA != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (in_fire) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                        ready_q   <= 1'b0;
                        state     <= FULL;
                    end else if (out_fire) begin
                        main_ctrl <= '0;
                        if (CLEAR_DATA != 0) begin
                            main_data <= '0;
                        end
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        skid_ctrl <= '0;
                        if (CLEAR_DATA != 0) begin
                            skid_data <= '0;
                        end
                        ready_q <= 1'b1;
                        state   <= ONE;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a queue model checked every cycle against two
// instances (CLEAR_DATA=0 and CLEAR_DATA=1) plus literal expectations per scenario.
module tb_pipe_stage_skid;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;

    logic          ir0, ov0, ir1, ov1;
    logic [CW-1:0] oc0, oc1;
    logic [DW-1:0] od0, od1;
    logic [1:0]    occ0, occ1;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t         q[$];
    logic [DW-1:0] last_data = '0;
    logic [CW-1:0] deliv[$];
    logic [CW-1:0] exp_q[$];
    int            maxocc = 0;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
        .occupancy(occ0)
    );

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
        .occupancy(occ1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] dat(input logic [CW-1:0] c);
        return 16'hA000 | 16'(c);
    endfunction

    task automatic drive(input logic v, input logic [CW-1:0] c);
        in_valid = v;
        in_ctrl  = c;
        in_data  = dat(c);
    endtask

    // Queue model: entries held in arrival order, front is what the stage presents.
    task automatic model_step();
        logic of_m;
        logic if_m;
        if (reset) begin
            q.delete();
            last_data = '0;
            return;
        end
        of_m = (q.size() > 0) && out_ready;
        if_m = in_valid && (q.size() < 2);
        if (flush) begin
            q.delete();
        end else begin
            if (of_m) void'(q.pop_front());
            if (if_m) q.push_back(beat_t'{c: in_ctrl, d: in_data});
        end
        if (q.size() > 0) last_data = q[0].d;
    endtask

    task automatic compare();
        logic          nv;
        logic [CW-1:0] ec;
        logic [DW-1:0] ed1;
        nv  = (q.size() > 0);
        ec  = nv ? q[0].c : '0;
        ed1 = nv ? q[0].d : '0;
        chk("out_valid_c0", 32'(ov0), 32'(nv));
        chk("out_valid_c1", 32'(ov1), 32'(nv));
        chk("out_ctrl_c0", 32'(oc0), 32'(ec));
        chk("out_ctrl_c1", 32'(oc1), 32'(ec));
        chk("in_ready_c0", 32'(ir0), 32'(q.size() < 2));
        chk("in_ready_c1", 32'(ir1), 32'(q.size() < 2));
        chk("occupancy_c0", 32'(occ0), 32'(q.size()));
        chk("occupancy_c1", 32'(occ1), 32'(q.size()));
        chk("out_data_c0", 32'(od0), 32'(last_data));
        chk("out_data_c1", 32'(od1), 32'(ed1));
    endtask

    task automatic cycle();
        if (ov0 && out_ready && !reset) deliv.push_back(oc0);
        @(posedge clk);
        model_step();
        #1;
        compare();
        if (int'(occ0) > maxocc) maxocc = int'(occ0);
    endtask

    task automatic check_seq(input string nm);
        int n;
        chk({nm, "_count"}, 32'(deliv.size()), 32'(exp_q.size()));
        n = (deliv.size() < exp_q.size()) ? deliv.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({nm, "_beat"}, 32'(deliv[i]), 32'(exp_q[i]));
    endtask

    initial begin
        // Reset state
        cycle();
        cycle();
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_out_ctrl", 32'(oc0), 32'd0);
        chk("rst_out_data", 32'(od0), 32'd0);
        chk("rst_in_ready", 32'(ir0), 32'd1);
        chk("rst_occupancy", 32'(occ0), 32'd0);
        reset = 1'b0;

        // Streaming 1..8 with out_ready=1
        deliv.delete();
        maxocc = 0;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, CW'(i));
            cycle();
        end
        drive(1'b0, '0);
        cycle();
        cycle();
        exp_q.delete();
        for (int i = 1; i <= 8; i++) exp_q.push_back(CW'(i));
        check_seq("stream");
        chk("stream_maxocc", 32'(maxocc), 32'd1);

        // Back-pressure: out_ready low for 3 cycles starting with the 0x22 cycle
        deliv.delete();
        maxocc = 0;
        drive(1'b1, 8'h11);
        cycle();
        out_ready = 1'b0;
        drive(1'b1, 8'h22);
        cycle();
        chk("bp_full_ready", 32'(ir0), 32'd0);
        chk("bp_full_occ", 32'(occ0), 32'd2);
        drive(1'b1, 8'h33);
        cycle();
        cycle();
        out_ready = 1'b1;
        cycle();
        chk("bp_recover_ready", 32'(ir0), 32'd1);
        cycle();
        drive(1'b0, '0);
        cycle();
        cycle();
        cycle();
        exp_q = '{8'h11, 8'h22, 8'h33};
        check_seq("bp");
        chk("bp_maxocc", 32'(maxocc), 32'd2);

        // Flush in FULL with a same-cycle input beat
        deliv.delete();
        out_ready = 1'b0;
        drive(1'b1, 8'h05);
        cycle();
        drive(1'b1, 8'h06);
        cycle();
        flush = 1'b1;
        drive(1'b1, 8'h07);
        cycle();
        chk("flfull_out_valid", 32'(ov0), 32'd0);
        chk("flfull_out_ctrl", 32'(oc0), 32'd0);
        chk("flfull_occ", 32'(occ0), 32'd0);
        chk("flfull_in_ready", 32'(ir0), 32'd1);
        chk("flfull_data_clear", 32'(od1), 32'd0);
        chk("flfull_data_hold", 32'(od0), 32'h0000A005);
        flush = 1'b0;
        drive(1'b0, '0);
        out_ready = 1'b1;
        cycle();
        cycle();
        cycle();
        exp_q.delete();
        check_seq("flfull");
        chk("flfull_data_hold_later", 32'(od0), 32'h0000A005);

        // Flush with simultaneous out_fire
        deliv.delete();
        drive(1'b1, 8'h09);
        cycle();
        drive(1'b0, '0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flfire_occ", 32'(occ0), 32'd0);
        chk("flfire_data_hold", 32'(od0), 32'h0000A009);
        chk("flfire_data_clear", 32'(od1), 32'd0);
        cycle();
        cycle();
        exp_q = '{8'h09};
        check_seq("flfire");

        // Asynchronous reset while FULL
        deliv.delete();
        out_ready = 1'b0;
        drive(1'b1, 8'h0A);
        cycle();
        drive(1'b1, 8'h0B);
        cycle();
        chk("arst_pre_occ", 32'(occ0), 32'd2);
        drive(1'b0, '0);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", 32'(ov0), 32'd0);
        chk("arst_out_ctrl", 32'(oc0), 32'd0);
        chk("arst_out_data_c0", 32'(od0), 32'd0);
        chk("arst_out_data_c1", 32'(od1), 32'd0);
        chk("arst_in_ready", 32'(ir0), 32'd1);
        chk("arst_occ", 32'(occ0), 32'd0);
        q.delete();
        last_data = '0;
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        cycle();
        cycle();
        exp_q.delete();
        check_seq("arst_none");
        drive(1'b1, 8'h0C);
        cycle();
        drive(1'b0, '0);
        cycle();
        cycle();
        exp_q = '{8'h0C};
        check_seq("arst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
